fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction-fetch stage of the 5-stage pipelined CPU.
- Owns the PC register and the PC+2 adder, selects the next PC (sequential / branch redirect), and drives the instruction-memory address.
- Registers the fetched instruction into the IF/ID buffer, which feeds decode.
- Implements stall (hold), flush (bubble insertion) and a halt state machine; exposes a fetch counter for the cpu_fixture debug dump.

Parameters:
ADDR_W, 16, PC / instruction-memory address width (byte addressed)
INSTR_W, 16, instruction width; PC increments by INSTR_W/8 = 2
RESET_PC, 16'h0000, PC value loaded on reset
NOP_INSTR, 16'h0000, instruction injected on flush/halt bubbles
CNT_W, 32, width of fetch counter

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
imem_addr  out  ADDR_W  instruction memory address (= PC), combinational from PC register
imem_rdata  in  INSTR_W  instruction memory read data, combinational, same cycle
pc_stop  in  1  hazard-unit stall: hold PC and IF/ID
if_id_flush  in  1  control-unit flush: load NOP_INSTR into IF/ID
branch_taken  in  1  redirect request from EX (if_pc_mux)
branch_target  in  ADDR_W  redirect address (ex_if_branch_location_result)
halt  in  1  control-unit halt (HALT decoded in ID)
id_instruction  out  INSTR_W  IF/ID instruction
id_pc_next_address  out  ADDR_W  IF/ID copy of PC+2 for the fetched instruction
id_valid  out  1  IF/ID holds a real instruction (0 = bubble)
halted  out  1  fetch is in HALTED state
target_misaligned  out  1  one-cycle pulse: branch_target bit0 was 1
fetch_count  out  CNT_W  instructions accepted into IF/ID since reset

Behaviour:
- Reset (reset=0, async): PC=RESET_PC, id_instruction=NOP_INSTR, id_pc_next_address=0, id_valid=0, halted=0, target_misaligned=0, fetch_count=0, state=START.
- States: START, RUN, HALTED.
- START: one bubble cycle after reset release. imem is not sampled; IF/ID keeps NOP with id_valid=0; PC is unchanged. Next state is RUN.
- RUN, per rising edge, priority as listed:
  1. branch_taken: PC <= {branch_target[ADDR_W-1:1],1'b0}; IF/ID <= NOP, id_valid=0. Overrides pc_stop, halt and if_id_flush. If branch_target[0]=1, target_misaligned=1 for one cycle.
  2. halt: state <= HALTED; PC frozen; IF/ID <= NOP, id_valid=0.
  3. pc_stop: PC and all IF/ID fields hold. If if_id_flush is also 1, IF/ID <= NOP with id_valid=0 while PC still holds.
  4. if_id_flush alone: PC <= PC+2; IF/ID <= NOP, id_valid=0 (fetched word discarded).
  5. Otherwise: IF/ID <= {imem_rdata, PC+2}, id_valid=1; PC <= PC+2; fetch_count++.
- HALTED: every input is ignored; PC, IF/ID (NOP) and fetch_count are frozen; halted=1. Only reset exits.
- Latency: the instruction at PC appears on id_instruction one cycle after imem_addr=PC.
- Arithmetic: PC+2 is modulo 2^ADDR_W (16'hFFFE → 16'h0000, no flag). fetch_count wraps silently.
- fetch_count increments only on case 5.
- Reset asserted mid-stall or mid-halt returns to the reset values immediately (asynchronously).

Decomposition:
- Shared package cpu_pkg holds: ADDR_W, INSTR_W, NOP_INSTR, RESET_PC, and the fetch state encoding (START=2'd0, RUN=2'd1, HALTED=2'd2).
- One natural sub-module: if_id_buffer (IF/ID register with hold/flush/valid). The PC, next-PC mux, FSM and counter stay in fetch_unit.

Test Plan:
- Straight-line: reset, imem returns 16'h1000+addr; release reset → after the START cycle, imem_addr = 0,2,4…; id_instruction = 1000,1002,1004… one cycle later; id_pc_next_address = 2,4,6; fetch_count counts 1,2,3.
- Stall: pc_stop=1 for 3 cycles at PC=6 → imem_addr stays 6, id_instruction frozen, fetch_count frozen; fetch resumes at 6 after release.
- Redirect vs stall: branch_taken=1, branch_target=16'h0041, pc_stop=1 in the same cycle → next PC=16'h0040, id_valid=0, target_misaligned pulses 1 cycle, fetch_count unchanged.
- Halt: halt=1 at PC=10 → halted=1 next cycle; PC stays 10 and id_valid=0 for ≥5 cycles despite branch_taken pulses; reset returns PC=0, halted=0.
- Wrap: branch to 16'hFFFE, then run → imem_addr = FFFE then 0000; id_pc_next_address=0000 for the FFFE instruction.
- Async reset mid-run: drop reset between clock edges at PC=8 → PC=0, id_valid=0, fetch_count=0 immediately, without waiting for an edge.

Source files
------------

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared widths, constants and fetch state encoding for the pipelined CPU
package cpu_pkg;
    localparam int ADDR_W = 16;
    localparam int INSTR_W = 16;
    localparam int CNT_W = 32;
    localparam logic [ADDR_W-1:0] RESET_PC = 16'h0000;
    localparam logic [INSTR_W-1:0] NOP_INSTR = 16'h0000;
    localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(INSTR_W / 8);
    typedef enum logic [1:0] {
        ST_START  = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2
    } fetch_state_e;
endpackage

// File: rtl/if_id_buffer.sv
// if_id_buffer: IF/ID pipeline register; load captures a fetch, flush inserts a bubble, else hold
module if_id_buffer
    import cpu_pkg::*;
(
    input  logic               clock,
    input  logic               reset,
    input  logic               load,
    input  logic               flush,
    input  logic [INSTR_W-1:0] instr_in,
    input  logic [ADDR_W-1:0]  pc_next_in,
    output logic [INSTR_W-1:0] instruction,
    output logic [ADDR_W-1:0]  pc_next,
    output logic               valid
);
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [ADDR_W-1:0]  pc_next_q, pc_next_d;
    logic               valid_q, valid_d;

    always_comb begin
        instr_d   = load ? instr_in   : flush ? NOP_INSTR : instr_q;
        pc_next_d = load ? pc_next_in : flush ? '0        : pc_next_q;
        valid_d   = load ? 1'b1       : flush ? 1'b0      : valid_q;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            instr_q   <= NOP_INSTR;
            pc_next_q <= '0;
            valid_q   <= 1'b0;
        end else begin
            instr_q   <= instr_d;
            pc_next_q <= pc_next_d;
            valid_q   <= valid_d;
        end
    end

    assign instruction = instr_q;
    assign pc_next     = pc_next_q;
    assign valid       = valid_q;
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: IF stage - PC register, next-PC select, start/run/halt FSM and fetch counter
module fetch_unit
    import cpu_pkg::*;
(
    input  logic               clock,
    input  logic               reset,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               pc_stop,
    input  logic               if_id_flush,
    input  logic               branch_taken,
    input  logic [ADDR_W-1:0]  branch_target,
    input  logic               halt,
    output logic [INSTR_W-1:0] id_instruction,
    output logic [ADDR_W-1:0]  id_pc_next_address,
    output logic               id_valid,
    output logic               halted,
    output logic               target_misaligned,
    output logic [CNT_W-1:0]   fetch_count
);
    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d, pc_inc;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              halted_q, halted_d;
    logic              mis_q, mis_d;
    logic              buf_load, buf_flush;

    assign pc_inc = pc_q + PC_STEP;

    // Priority in RUN: redirect > halt > stall (optionally flushing) > flush > fetch
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        cnt_d     = cnt_q;
        halted_d  = halted_q;
        mis_d     = 1'b0;
        buf_load  = 1'b0;
        buf_flush = 1'b0;
        case (state_q)
            ST_START: state_d = ST_RUN;
            ST_RUN: begin
                if (branch_taken) begin
                    pc_d      = {branch_target[ADDR_W-1:1], 1'b0};
                    mis_d     = branch_target[0];
                    buf_flush = 1'b1;
                end else if (halt) begin
                    state_d   = ST_HALTED;
                    halted_d  = 1'b1;
                    buf_flush = 1'b1;
                end else if (pc_stop) begin
                    buf_flush = if_id_flush;
                end else if (if_id_flush) begin
                    pc_d      = pc_inc;
                    buf_flush = 1'b1;
                end else begin
                    pc_d      = pc_inc;
                    cnt_d     = cnt_q + 1'b1;
                    buf_load  = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_START;
            pc_q     <= RESET_PC;
            cnt_q    <= '0;
            halted_q <= 1'b0;
            mis_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            cnt_q    <= cnt_d;
            halted_q <= halted_d;
            mis_q    <= mis_d;
        end
    end

    if_id_buffer u_if_id (
        .clock      (clock),
        .reset      (reset),
        .load       (buf_load),
        .flush      (buf_flush),
        .instr_in   (imem_rdata),
        .pc_next_in (pc_inc),
        .instruction(id_instruction),
        .pc_next    (id_pc_next_address),
        .valid      (id_valid)
    );

    assign imem_addr         = pc_q;
    assign halted            = halted_q;
    assign target_misaligned = mis_q;
    assign fetch_count       = cnt_q;
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: randomized and directed stimulus against a reference model, scoreboard-checked
module tb_fetch_unit;
    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] imem_addr;
    logic [15:0] imem_rdata;
    logic        pc_stop = 1'b0;
    logic        if_id_flush = 1'b0;
    logic        branch_taken = 1'b0;
    logic [15:0] branch_target = '0;
    logic        halt = 1'b0;
    logic [15:0] id_instruction;
    logic [15:0] id_pc_next_address;
    logic        id_valid;
    logic        halted;
    logic        target_misaligned;
    logic [31:0] fetch_count;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [15:0] addr;
        logic [15:0] instr;
        logic [15:0] pcn;
        logic        valid;
        logic        halted;
        logic        mis;
        logic [31:0] cnt;
    } exp_t;
    exp_t sb[$];

    // reference model state
    logic [15:0] m_pc;
    logic        m_started, m_halted, m_valid, m_mis;
    logic [15:0] m_instr, m_pcn;
    logic [31:0] m_cnt;

    always #5 clock = ~clock;
    assign imem_rdata = 16'h1000 + imem_addr;

    fetch_unit dut (
        .clock             (clock),
        .reset             (reset),
        .imem_addr         (imem_addr),
        .imem_rdata        (imem_rdata),
        .pc_stop           (pc_stop),
        .if_id_flush       (if_id_flush),
        .branch_taken      (branch_taken),
        .branch_target     (branch_target),
        .halt              (halt),
        .id_instruction    (id_instruction),
        .id_pc_next_address(id_pc_next_address),
        .id_valid          (id_valid),
        .halted            (halted),
        .target_misaligned (target_misaligned),
        .fetch_count       (fetch_count)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_pc = 16'h0000; m_started = 0; m_halted = 0; m_valid = 0; m_mis = 0;
        m_instr = 16'h0000; m_pcn = 16'h0000; m_cnt = 0;
    endtask

    function automatic void bubble();
        m_instr = 16'h0000; m_valid = 0;
    endfunction

    // One clock of the architectural rules, applied to the inputs about to be sampled
    task automatic model_step(input logic br, input logic [15:0] tgt, input logic hl,
                              input logic st, input logic fl);
        exp_t e;
        m_mis = 0;
        if (m_halted) begin
        end else if (!m_started) begin
            m_started = 1;
        end else if (br) begin
            m_pc = tgt & 16'hFFFE; m_mis = tgt[0]; bubble();
        end else if (hl) begin
            m_halted = 1; bubble();
        end else if (st) begin
            if (fl) bubble();
        end else if (fl) begin
            m_pc = m_pc + 16'd2; bubble();
        end else begin
            m_instr = 16'h1000 + m_pc; m_pcn = m_pc + 16'd2; m_valid = 1;
            m_pc = m_pc + 16'd2; m_cnt = m_cnt + 1;
        end
        e.addr = m_pc; e.instr = m_instr; e.pcn = m_pcn; e.valid = m_valid;
        e.halted = m_halted; e.mis = m_mis; e.cnt = m_cnt;
        sb.push_back(e);
    endtask

    // Called just after a negedge: drives inputs for the next posedge and waits a full cycle
    task automatic cycle(input logic br, input logic [15:0] tgt, input logic hl,
                         input logic st, input logic fl);
        branch_taken = br; branch_target = tgt; halt = hl; pc_stop = st; if_id_flush = fl;
        model_step(br, tgt, hl, st, fl);
        @(negedge clock);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle(0, 16'h0, 0, 0, 0);
    endtask

    // Reset is asserted between edges and checked before any edge can occur
    task automatic do_reset();
        reset = 1'b0;
        #1;
        chk("rst_addr", 32'(imem_addr), 32'h0);
        chk("rst_instr", 32'(id_instruction), 32'h0);
        chk("rst_pcn", 32'(id_pc_next_address), 32'h0);
        chk("rst_valid", 32'(id_valid), 32'h0);
        chk("rst_halted", 32'(halted), 32'h0);
        chk("rst_mis", 32'(target_misaligned), 32'h0);
        chk("rst_cnt", fetch_count, 32'h0);
        model_reset();
        branch_taken = 0; halt = 0; pc_stop = 0; if_id_flush = 0;
        @(negedge clock);
        reset = 1'b1;
    endtask

    // Monitor: every output update after a rising edge is popped and compared
    initial begin
        exp_t e;
        forever begin
            @(posedge clock);
            #1;
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("imem_addr", 32'(imem_addr), 32'(e.addr));
                chk("id_valid", 32'(id_valid), 32'(e.valid));
                chk("id_instruction", 32'(id_instruction), 32'(e.instr));
                if (e.valid) chk("id_pc_next", 32'(id_pc_next_address), 32'(e.pcn));
                chk("halted", 32'(halted), 32'(e.halted));
                chk("target_misaligned", 32'(target_misaligned), 32'(e.mis));
                chk("fetch_count", fetch_count, e.cnt);
            end
        end
    end

    initial begin
        model_reset();
        @(negedge clock);
        do_reset();
        // straight line, then 3-cycle stall at PC=6
        run(4);
        chk("pc_at_stall", 32'(m_pc), 32'h6);
        for (int i = 0; i < 3; i++) cycle(0, 16'h0, 0, 1, 0);
        run(3);
        // redirect beats stall, misaligned target
        cycle(1, 16'h0041, 0, 1, 0);
        run(2);
        // wrap through FFFE
        cycle(1, 16'hFFFE, 0, 0, 0);
        run(3);
        // stall+flush and flush alone
        cycle(0, 16'h0, 0, 1, 1);
        cycle(0, 16'h0, 0, 0, 1);
        run(2);
        // randomized traffic without halt
        for (int i = 0; i < 400; i++)
            cycle($urandom_range(0, 7) == 0, 16'($urandom), 0,
                  $urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0);
        // halt at PC=10, then ignore everything
        do_reset();
        run(6);
        cycle(0, 16'h0, 1, 0, 0);
        for (int i = 0; i < 6; i++)
            cycle(i % 2 == 0, 16'($urandom), $urandom_range(0, 1) == 1,
                  $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
        do_reset();
        // async reset mid-run at PC=8
        run(5);
        chk("pc_before_async", 32'(imem_addr), 32'h8);
        #2;
        do_reset();
        run(3);
        @(negedge clock);
        chk("scoreboard_drained", 32'(sb.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
